// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared FSM state encoding and LFSR tap mask for the bounce generator
// Contents: bg_state_e (IDLE/BOUNCE/SETTLE), LFSR_TAPS for x^16+x^14+x^13+x^11+1
package bounce_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2} bg_state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, loaded with seed on reset
// Ports: clk, reset (sync, active-high), seed[15:0] reset value, q[15:0] current state
module lfsr16 import bounce_gen_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= seed;
    else q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: emulates a bouncy mechanical contact with random odd glitch gaps, then a long settle
// Ports: clk, reset (sync, active-high), start (request), level (final level), n_bounce[3:0] (glitch count),
//        sw (emulated contact), busy (operation in progress incl. done_tick), done_tick (end-of-settle pulse)
module bounce_gen import bounce_gen_pkg::*; #(
  parameter int          GAP_W      = 8,
  parameter int          SETTLE_CYC = 2500000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       level,
  input  logic [3:0] n_bounce,
  output logic       sw,
  output logic       busy,
  output logic       done_tick
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
  bg_state_e        state_q;
  logic [15:0]      lfsr;
  logic             sw_q, busy_q, done_q, lvl_q;
  logic [3:0]       n_q;
  logic [4:0]       tog_q;
  logic [GAP_W-1:0] gap_q;
  logic [SW-1:0]    set_q;
  logic [GAP_W-1:0] g;
  logic             last_tog, accept, unused_bits;
  lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(LFSR_SEED), .q(lfsr));
  // forcing the LSB high keeps every gap odd and non-zero
  assign g = {lfsr[GAP_W-1:1], 1'b1};
  assign unused_bits = ^lfsr;
  assign last_tog = (tog_q + 5'd1) == {n_q, 1'b0};
  // a start coinciding with done_tick is dropped so the pulse is always followed by one idle cycle
  assign accept = start && !done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lvl_q   <= 1'b0;
      n_q     <= '0;
      tog_q   <= '0;
      gap_q   <= '0;
      set_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= accept;
          if (accept) begin
            sw_q    <= level;
            lvl_q   <= level;
            n_q     <= n_bounce;
            tog_q   <= '0;
            gap_q   <= g;
            set_q   <= '0;
            state_q <= n_bounce == 4'd0 ? SETTLE : BOUNCE;
          end
        end
        BOUNCE:
          if (gap_q == GAP_W'(1)) begin
            sw_q    <= last_tog ? lvl_q : ~sw_q;
            tog_q   <= tog_q + 5'd1;
            gap_q   <= g;
            state_q <= last_tog ? SETTLE : BOUNCE;
          end else gap_q <= gap_q - 1'b1;
        SETTLE:
          if (set_q == SET_LAST) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else set_q <= set_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sw        = sw_q;
  assign busy      = busy_q;
  assign done_tick = done_q;
endmodule
